// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla-core types: the remote request payload carried from the tile
// to the network link.
package bsg_vanilla_pkg;

   typedef struct packed {
      logic        write_not_read;
      logic [3:0]  mask;
      logic [31:0] addr;
      logic [31:0] data;
   } remote_req_s;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small 1-read/1-write FIFO with a registered ready. With ready_THEN_valid_p set,
// the producer only raises v_i when ready_o is high.
module bsg_fifo_1r1w_small #(
   parameter int unsigned width_p            = 8,
   parameter int unsigned els_p              = 2,
   parameter int unsigned ready_THEN_valid_p = 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   localparam int unsigned ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int unsigned cnt_width_lp = $clog2(els_p + 1);

   logic [width_p-1:0]      mem_q [els_p];
   logic [ptr_width_lp-1:0] wptr_q, wptr_d;
   logic [ptr_width_lp-1:0] rptr_q, rptr_d;
   logic [cnt_width_lp-1:0] cnt_q, cnt_d;
   logic                    ready_q, ready_d;
   logic                    enq, deq;

   function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
      return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
   endfunction

   assign enq     = v_i & (ready_q | (ready_THEN_valid_p != 0));
   assign deq     = yumi_i;
   assign ready_o = ready_q;
   assign v_o     = (cnt_q != '0);
   assign data_o  = mem_q[rptr_q];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (enq) wptr_d = ptr_inc(wptr_q);
      if (deq) rptr_d = ptr_inc(rptr_q);
      unique case ({enq, deq})
         2'b10:   cnt_d = cnt_q + cnt_width_lp'(1);
         2'b01:   cnt_d = cnt_q - cnt_width_lp'(1);
         default: cnt_d = cnt_q;
      endcase
      // Ready looks at next occupancy so a full buffer never sees enqueue and dequeue together
      ready_d = (cnt_d != cnt_width_lp'(els_p));
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/vanilla_remote_req_credit_gate.sv
// Gates remote requests onto the network link by available credits and tracks
// outstanding DMA-issued requests so the DMA engine can tell when it is idle.
module vanilla_remote_req_credit_gate
   import bsg_vanilla_pkg::*;
#(
   parameter  int unsigned credit_max_p    = 32,
   parameter  int unsigned els_p           = 2,
   localparam int unsigned credit_width_lp = $clog2(credit_max_p + 1)
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       req_v_i,
   input  remote_req_s                req_i,
   input  logic                       req_dma_i,
   output logic                       req_ready_o,
   output logic                       out_v_o,
   output remote_req_s                out_req_o,
   input  logic                       out_ready_i,
   input  logic                       credit_return_v_i,
   input  logic                       credit_return_dma_i,
   output logic [credit_width_lp-1:0] credit_count_o,
   output logic                       all_returned_o,
   output logic                       dma_idle_o
);

   localparam int unsigned req_width_lp     = $bits(remote_req_s);
   localparam int unsigned buf_cnt_width_lp = $clog2(els_p + 1);
   localparam logic [credit_width_lp-1:0] credit_max_lp = credit_width_lp'(credit_max_p);

   logic [req_width_lp:0]           fifo_data_in, fifo_data_out;
   logic                            fifo_ready, fifo_v;
   logic                            enq, send, head_dma, dma_send, dma_ret;
   logic [credit_width_lp-1:0]      credit_q, credit_d;
   logic [credit_width_lp-1:0]      dma_out_q, dma_out_d;
   logic [buf_cnt_width_lp-1:0]     dma_buf_q, dma_buf_d;
   logic                            credit_overflow_c, dma_underflow_c;

   assign fifo_data_in = {req_dma_i, req_i};

   bsg_fifo_1r1w_small #(
      .width_p            (req_width_lp + 1),
      .els_p              (els_p),
      .ready_THEN_valid_p (1)
   ) req_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (enq),
      .ready_o (fifo_ready),
      .data_i  (fifo_data_in),
      .v_o     (fifo_v),
      .data_o  (fifo_data_out),
      .yumi_i  (send)
   );

   assign head_dma    = fifo_data_out[req_width_lp];
   assign out_req_o   = fifo_data_out[req_width_lp-1:0];
   assign req_ready_o = fifo_ready & ~reset_i;
   assign enq         = req_v_i & req_ready_o;
   assign out_v_o     = fifo_v & (credit_q != '0) & ~reset_i;
   assign send        = out_v_o & out_ready_i;
   assign dma_send    = send & head_dma;
   assign dma_ret     = credit_return_v_i & credit_return_dma_i;

   // Counter next-state; overflow/underflow conditions are held, not applied
   always_comb begin
      credit_d          = credit_q;
      dma_out_d         = dma_out_q;
      dma_buf_d         = dma_buf_q;
      credit_overflow_c = 1'b0;
      dma_underflow_c   = 1'b0;

      unique case ({send, credit_return_v_i})
         2'b10: credit_d = credit_q - credit_width_lp'(1);
         2'b01: begin
            if (credit_q == credit_max_lp) credit_overflow_c = 1'b1;
            else                           credit_d = credit_q + credit_width_lp'(1);
         end
         default: credit_d = credit_q;
      endcase

      if (dma_send & ~dma_ret) begin
         dma_out_d = dma_out_q + credit_width_lp'(1);
      end else if (dma_ret & ~dma_send) begin
         if (dma_out_q == '0) dma_underflow_c = 1'b1;
         else                 dma_out_d = dma_out_q - credit_width_lp'(1);
      end

      unique case ({enq & req_dma_i, dma_send})
         2'b10:   dma_buf_d = dma_buf_q + buf_cnt_width_lp'(1);
         2'b01:   dma_buf_d = dma_buf_q - buf_cnt_width_lp'(1);
         default: dma_buf_d = dma_buf_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         credit_q  <= credit_max_lp;
         dma_out_q <= '0;
         dma_buf_q <= '0;
      end else begin
         credit_q  <= credit_d;
         dma_out_q <= dma_out_d;
         dma_buf_q <= dma_buf_d;
      end
   end

   // Returns are counted by the network; a surplus means an upstream accounting bug
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!credit_overflow_c) else $error("credit return with all credits present");
         assert (!dma_underflow_c)   else $error("DMA credit return with none outstanding");
      end
   end

   assign credit_count_o = reset_i ? credit_max_lp : credit_q;
   assign all_returned_o = reset_i | ((credit_q == credit_max_lp) & ~fifo_v);
   assign dma_idle_o     = reset_i | ((dma_out_q == '0) & (dma_buf_q == '0));

endmodule

// File: tb/tb_vanilla_remote_req_credit_gate.sv
// Scoreboard bench for the remote request credit gate (credit_max_p=4, els_p=2).
module tb_vanilla_remote_req_credit_gate;
   import bsg_vanilla_pkg::*;

   localparam int unsigned CMAX = 4;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        req_v_i = 1'b0;
   remote_req_s req_i = '0;
   logic        req_dma_i = 1'b0;
   logic        req_ready_o;
   logic        out_v_o;
   remote_req_s out_req_o;
   logic        out_ready_i = 1'b0;
   logic        credit_return_v_i = 1'b0;
   logic        credit_return_dma_i = 1'b0;
   logic [2:0]  credit_count_o;
   logic        all_returned_o;
   logic        dma_idle_o;

   int          n_chk = 0;
   int          n_bad = 0;
   int          n_sent = 0;
   int          credit_m = CMAX;
   remote_req_s sb_q [$];

   vanilla_remote_req_credit_gate #(.credit_max_p(CMAX), .els_p(2)) dut (
      .clk_i               (clk_i),
      .reset_i             (reset_i),
      .req_v_i             (req_v_i),
      .req_i               (req_i),
      .req_dma_i           (req_dma_i),
      .req_ready_o         (req_ready_o),
      .out_v_o             (out_v_o),
      .out_req_o           (out_req_o),
      .out_ready_i         (out_ready_i),
      .credit_return_v_i   (credit_return_v_i),
      .credit_return_dma_i (credit_return_dma_i),
      .credit_count_o      (credit_count_o),
      .all_returned_o      (all_returned_o),
      .dma_idle_o          (dma_idle_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic remote_req_s mk(input int n);
      remote_req_s r;
      r.write_not_read = n[0];
      r.mask           = 4'(n);
      r.addr           = 32'h1000 + 32'(n);
      r.data           = 32'(n) * 32'h0101_0101;
      return r;
   endfunction

   // Present one request and wait (bounded) until it is accepted
   task automatic send_req(input int n, input logic dma);
      logic acc;
      acc       = 1'b0;
      req_v_i   = 1'b1;
      req_i     = mk(n);
      req_dma_i = dma;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk_i);
         acc = req_ready_o;
         tick();
      end
      if (!acc) chk("accept_timeout", 0, 1);
      req_v_i   = 1'b0;
      req_dma_i = 1'b0;
   endtask

   // Monitor: handshakes are resolved mid-cycle, away from the active edge
   always @(negedge clk_i) begin
      if (reset_i) begin
         sb_q.delete();
         credit_m = CMAX;
      end else begin
         logic snd;
         remote_req_s exp_r;
         chk("credit_model", credit_count_o, credit_m);
         chk("out_v_model", out_v_o, (sb_q.size() != 0) && (credit_m != 0));
         snd = out_v_o & out_ready_i;
         if (snd) begin
            n_sent++;
            if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               exp_r = sb_q.pop_front();
               chk("order", out_req_o, exp_r);
            end
         end
         if (req_v_i & req_ready_o) sb_q.push_back(req_i);
         if (snd && !credit_return_v_i) credit_m--;
         else if (!snd && credit_return_v_i && credit_m < CMAX) credit_m++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      chk("rst_credit", credit_count_o, CMAX);
      chk("rst_out_v", out_v_o, 0);
      chk("rst_ready", req_ready_o, 0);
      reset_i = 1'b0;
      tick();
      chk("post_rst_ready", req_ready_o, 1);
      chk("post_rst_all_ret", all_returned_o, 1);
      chk("post_rst_dma_idle", dma_idle_o, 1);

      // Exhaust credits; 5th request must be held
      out_ready_i = 1'b1;
      for (int k = 1; k <= 5; k++) send_req(k, 1'b0);
      repeat (3) tick();
      chk("exhaust_credit", credit_count_o, 0);
      chk("exhaust_out_v", out_v_o, 0);
      chk("exhaust_sent", n_sent, 4);
      chk("exhaust_all_ret", all_returned_o, 0);

      // One return releases the held request a cycle later
      credit_return_v_i = 1'b1;
      @(negedge clk_i);
      chk("ret_same_cycle_out_v", out_v_o, 0);
      tick();
      credit_return_v_i = 1'b0;
      chk("ret_credit1", credit_count_o, 1);
      chk("ret_out_v", out_v_o, 1);
      tick();
      chk("ret_credit0", credit_count_o, 0);
      chk("ret_out_v_low", out_v_o, 0);
      chk("ret_sent", n_sent, 5);

      // Simultaneous send and return at count 2
      credit_return_v_i = 1'b1;
      tick();
      tick();
      credit_return_v_i = 1'b0;
      out_ready_i = 1'b0;
      send_req(6, 1'b0);
      tick();
      chk("pre_both_credit", credit_count_o, 2);
      out_ready_i = 1'b1;
      credit_return_v_i = 1'b1;
      @(negedge clk_i);
      chk("both_out_v", out_v_o, 1);
      tick();
      credit_return_v_i = 1'b0;
      chk("both_credit", credit_count_o, 2);
      chk("both_sent", n_sent, 6);
      credit_return_v_i = 1'b1;
      tick();
      tick();
      credit_return_v_i = 1'b0;
      chk("refill_all_ret", all_returned_o, 1);

      // DMA tracking
      send_req(7, 1'b1);
      send_req(8, 1'b1);
      repeat (3) tick();
      chk("dma_credit", credit_count_o, 2);
      chk("dma_busy", dma_idle_o, 0);
      credit_return_v_i = 1'b1;
      credit_return_dma_i = 1'b1;
      tick();
      chk("dma_one_left", dma_idle_o, 0);
      tick();
      credit_return_v_i = 1'b0;
      credit_return_dma_i = 1'b0;
      chk("dma_idle", dma_idle_o, 1);
      chk("dma_all_ret", all_returned_o, 1);

      // Backpressure: buffer fills after two, order kept on release
      out_ready_i = 1'b0;
      send_req(9, 1'b0);
      send_req(10, 1'b0);
      chk("full_ready", req_ready_o, 0);
      req_v_i = 1'b1;
      req_i = mk(11);
      tick();
      tick();
      chk("full_ready_held", req_ready_o, 0);
      chk("full_out_v", out_v_o, 1);
      out_ready_i = 1'b1;
      send_req(11, 1'b0);
      repeat (4) tick();
      chk("bp_sent", n_sent, 11);
      chk("bp_credit", credit_count_o, 1);

      // Reset mid-operation with two buffered DMA requests
      out_ready_i = 1'b0;
      send_req(12, 1'b1);
      send_req(13, 1'b1);
      tick();
      chk("pre_rst_dma_busy", dma_idle_o, 0);
      chk("pre_rst_credit", credit_count_o, 1);
      reset_i = 1'b1;
      credit_return_v_i = 1'b1;
      credit_return_dma_i = 1'b1;
      tick();
      tick();
      credit_return_v_i = 1'b0;
      credit_return_dma_i = 1'b0;
      tick();
      reset_i = 1'b0;
      tick();
      chk("mid_rst_credit", credit_count_o, CMAX);
      chk("mid_rst_out_v", out_v_o, 0);
      chk("mid_rst_all_ret", all_returned_o, 1);
      chk("mid_rst_dma_idle", dma_idle_o, 1);
      chk("mid_rst_ready", req_ready_o, 1);

      out_ready_i = 1'b1;
      send_req(14, 1'b0);
      repeat (3) tick();
      chk("final_sent", n_sent, 12);
      chk("final_sb_empty", sb_q.size(), 0);
      chk("final_credit", credit_count_o, 3);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
